// File: rtl/attn_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : attn_seq_pkg                                                    |
// | Purpose  : Shared types and instruction-bus encoding for attn_core_seq.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package attn_seq_pkg;

  localparam int INST_W     = 17;
  localparam int ADD_W      = 4;

  localparam int OFIFO_RD   = 16;
  localparam int QK_ADD_LSB = 12;
  localparam int P_ADD_LSB  = 8;
  localparam int MAC_LSB    = 6;
  localparam int QRD        = 5;
  localparam int QWR        = 4;
  localparam int KRD        = 3;
  localparam int KWR        = 2;
  localparam int PRD        = 1;
  localparam int PWR        = 0;

  localparam logic [1:0] MAC_NOP   = 2'b00;
  localparam logic [1:0] MAC_KLOAD = 2'b01;
  localparam logic [1:0] MAC_EXEC  = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_Q    = 4'd1,
    ST_LOAD_K    = 4'd2,
    ST_KLOAD     = 4'd3,
    ST_GAP       = 4'd4,
    ST_EXEC      = 4'd5,
    ST_DRAIN     = 4'd6,
    ST_NORM_RD   = 4'd7,
    ST_NORM_WAIT = 4'd8,
    ST_DONE      = 4'd9
  } state_t;

endpackage
`default_nettype wire

// File: rtl/attn_core_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : attn_core_seq                                                   |
// | Purpose  : Instruction sequencer driving one attention pass per start.     |
// |            ATTN_SEQ_PERF_CNT_EN adds the perf_cycles busy-cycle counter.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module attn_core_seq
  import attn_seq_pkg::*;
#(
  parameter int NUM_Q   = 16,
  parameter int COL     = 8,
  parameter int ADDR_BW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ofifo_valid,
  input  logic              norm_done,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
`ifdef ATTN_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int CW = ADDR_BW + 1;
  localparam logic [CW-1:0] c_one    = CW'(1);
  localparam logic [CW-1:0] c_col    = CW'(COL);
  localparam logic [CW-1:0] c_num_q  = CW'(NUM_Q);
  localparam logic [CW-1:0] c_last_q = CW'(NUM_Q - 1);
  localparam logic [CW-1:0] c_last_k = CW'(COL - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [1:0]          r_mac;
  logic [1:0]          w_mac_nxt;
  logic [ADD_W-1:0]    w_addr;
  logic [INST_W-1:0]   w_inst;
  logic                w_in_ready;
  logic                w_done;

  assign w_addr = ADD_W'(r_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mac   <= MAC_NOP;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mac   <= w_mac_nxt;
    end
  end

  // r_mac lags the SRAM read command by one cycle so the MAC op meets the read data.
  always_comb begin
    w_state_nxt                = r_state;
    w_cnt_nxt                  = r_cnt;
    w_mac_nxt                  = MAC_NOP;
    w_inst                     = '0;
    w_inst[MAC_LSB +: 2]       = r_mac;
    w_in_ready                 = 1'b0;
    w_done                     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LOAD_Q;
          w_cnt_nxt   = '0;
        end
      end
      ST_LOAD_Q: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_inst[QWR]                  = 1'b1;
          w_inst[QK_ADD_LSB +: ADD_W]  = w_addr;
          if (r_cnt == c_last_q) begin
            w_state_nxt = ST_LOAD_K;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
      end
      ST_LOAD_K: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_inst[KWR]                  = 1'b1;
          w_inst[QK_ADD_LSB +: ADD_W]  = w_addr;
          if (r_cnt == c_last_k) begin
            w_state_nxt = ST_KLOAD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
      end
      ST_KLOAD: begin
        if (r_cnt < c_col) begin
          w_inst[KRD]                  = 1'b1;
          w_inst[QK_ADD_LSB +: ADD_W]  = w_addr;
          w_mac_nxt                    = MAC_KLOAD;
          w_cnt_nxt                    = r_cnt + c_one;
        end else begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (r_cnt < c_num_q) begin
          w_inst[QRD]                  = 1'b1;
          w_inst[QK_ADD_LSB +: ADD_W]  = w_addr;
          w_mac_nxt                    = MAC_EXEC;
          w_cnt_nxt                    = r_cnt + c_one;
        end else begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        if (ofifo_valid) begin
          w_inst[OFIFO_RD]             = 1'b1;
          w_inst[PWR]                  = 1'b1;
          w_inst[P_ADD_LSB +: ADD_W]   = w_addr;
          if (r_cnt == c_last_q) begin
            w_state_nxt = ST_NORM_RD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
      end
      ST_NORM_RD: begin
        w_inst[PRD]                    = 1'b1;
        w_inst[P_ADD_LSB +: ADD_W]     = w_addr;
        w_state_nxt                    = ST_NORM_WAIT;
      end
      ST_NORM_WAIT: begin
        if (norm_done) begin
          if (r_cnt == c_last_q) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt   = r_cnt + c_one;
            w_state_nxt = ST_NORM_RD;
          end
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign inst     = w_inst;
  assign in_ready = w_in_ready;
  assign done     = w_done;
  assign busy     = (r_state != ST_IDLE);

`ifdef ATTN_SEQ_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_perf <= '0;
    end else if (r_state != ST_IDLE && r_perf != 32'hFFFF_FFFF) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule
`default_nettype wire
